rtc_set_ctrl: RTL and testbench

Button-driven time-set controller for the real-time clock. It conditions three push-buttons and runs a set-mode state machine that snapshots the running time into shadow registers. The user edits hour, then minute, and the block commits the result to the RTC counters with a one-cycle load strobe. It sits between the board buttons and the `rtc` counter block, and it also drives shadow values and blink enables to the 7-segment display mux.

---
 rtl/rtc_pkg.sv | 28 ++
 rtl/button_conditioner.sv | 67 ++++++
 rtl/rtc_set_ctrl.sv | 121 ++++++++++++
 tb/tb_rtc_set_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types, field limits and wrap helpers for the RTC time-set path
package rtc_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    COMMIT   = 2'd3
  } set_state_t;

  // Fields wrap independently; there is never a carry into the neighbouring field.
  function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] h, input logic up);
    if (up) return (h == HOUR_W'(HOUR_MAX)) ? '0 : h + HOUR_W'(1);
    return (h == '0) ? HOUR_W'(HOUR_MAX) : h - HOUR_W'(1);
  endfunction

  function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] m, input logic up);
    if (up) return (m == MIN_W'(MIN_MAX)) ? '0 : m + MIN_W'(1);
    return (m == '0) ? MIN_W'(MIN_MAX) : m - MIN_W'(1);
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - synchronizer, debounce, press pulse and optional auto-repeat for one button
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW   = $clog2(RMAX + 1);

  logic          sync1, sync2, db;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] rep_cnt;
  logic          repeating;
  logic          accept;
  logic          rep_fire;

  assign accept   = (sync2 != db) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
  // First repeat waits HOLD_CYCLES after the press, later ones REPEAT_CYCLES apart.
  assign rep_fire = REPEAT_EN && db &&
                    (repeating ? (rep_cnt == RW'(REPEAT_CYCLES - 1))
                               : (rep_cnt == RW'(HOLD_CYCLES - 1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db        <= 1'b0;
      db_cnt    <= '0;
      rep_cnt   <= '0;
      repeating <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;

      if (sync2 == db) begin
        db_cnt <= '0;
      end else if (accept) begin
        db     <= sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      press <= (accept && sync2) || rep_fire;

      if (!db) begin
        rep_cnt   <= '0;
        repeating <= 1'b0;
      end else if (rep_fire) begin
        rep_cnt   <= '0;
        repeating <= 1'b1;
      end else begin
        rep_cnt   <= rep_cnt + RW'(1);
      end
    end
  end

endmodule

// File: rtl/rtc_set_ctrl.sv
// rtl/rtc_set_ctrl.sv - button-driven set-mode controller that edits and commits RTC hour/minute
module rtc_set_ctrl
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter int TIMEOUT_SECS    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sec_clk,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  output logic              load,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MIN_W-1:0]  load_min,
  output logic [SEC_W-1:0]  load_sec,
  output logic              set_active,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic              blink_hour,
  output logic              blink_min
);

  localparam int TW = $clog2(TIMEOUT_SECS + 1);

  set_state_t        state;
  logic [HOUR_W-1:0] hour_sh;
  logic [MIN_W-1:0]  min_sh;
  logic [TW-1:0]     tcnt;
  logic              phase;
  logic              ev_mode, ev_inc, ev_dec;
  logic              ev_any, step_up, step_dn;

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)
  ) u_mode (.clk(clk), .reset(reset), .btn(btn_mode), .press(ev_mode));

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_inc (.clk(clk), .reset(reset), .btn(btn_inc), .press(ev_inc));

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .HOLD_CYCLES(HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_dec (.clk(clk), .reset(reset), .btn(btn_dec), .press(ev_dec));

  // Mode beats inc/dec; inc together with dec cancels out.
  assign ev_any  = ev_mode | ev_inc | ev_dec;
  assign step_up = ev_inc & ~ev_dec & ~ev_mode;
  assign step_dn = ev_dec & ~ev_inc & ~ev_mode;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      hour_sh   <= '0;
      min_sh    <= '0;
      tcnt      <= '0;
      phase     <= 1'b0;
      load      <= 1'b0;
      load_hour <= '0;
      load_min  <= '0;
      load_sec  <= '0;
    end else begin
      load <= 1'b0;
      case (state)
        RUN: begin
          if (ev_mode) begin
            hour_sh <= cur_hour;
            min_sh  <= cur_min;
            tcnt    <= '0;
            phase   <= 1'b0;
            state   <= SET_HOUR;
          end
        end
        SET_HOUR, SET_MIN: begin
          if (sec_clk) phase <= ~phase;
          if (ev_any) begin
            tcnt <= '0;
          end else if (sec_clk) begin
            if (tcnt == TW'(TIMEOUT_SECS - 1)) begin
              tcnt  <= '0;
              state <= RUN;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          if (ev_mode) begin
            if (state == SET_HOUR) begin
              state <= SET_MIN;
            end else begin
              state     <= COMMIT;
              load      <= 1'b1;
              load_hour <= hour_sh;
              load_min  <= min_sh;
              load_sec  <= '0;
            end
          end else if (step_up || step_dn) begin
            if (state == SET_HOUR) hour_sh <= step_hour(hour_sh, step_up);
            else                   min_sh  <= step_min(min_sh, step_up);
          end
        end
        COMMIT:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  assign set_active = (state == SET_HOUR) || (state == SET_MIN);
  assign disp_hour  = hour_sh;
  assign disp_min   = min_sh;
  assign blink_hour = (state == SET_HOUR) && phase;
  assign blink_min  = (state == SET_MIN) && phase;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// tb/tb_rtc_set_ctrl.sv - randomized self-checking bench for rtc_set_ctrl against a field-level model
module tb_rtc_set_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam int TOUT = 3;

  logic       clk = 1'b0;
  logic       reset, sec_clk, btn_mode, btn_inc, btn_dec;
  logic [4:0] cur_hour;
  logic [5:0] cur_min;
  logic       load, set_active, blink_hour, blink_min;
  logic [4:0] load_hour, disp_hour;
  logic [5:0] load_min, load_sec, disp_min;

  always #5 clk = ~clk;

  rtc_set_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .TIMEOUT_SECS(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .sec_clk(sec_clk),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hour(cur_hour), .cur_min(cur_min),
    .load(load), .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .set_active(set_active), .disp_hour(disp_hour), .disp_min(disp_min),
    .blink_hour(blink_hour), .blink_min(blink_min)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model: mode 0=run 1=hour 2=min; expected commits as hour*64+min.
  int m_st, m_h, m_m, m_phase, m_tcnt;
  int exp_q[$];
  int exp_total  = 0;
  int loads_seen = 0;

  always @(negedge clk) begin
    if (load) begin
      loads_seen++;
      if (exp_q.size() == 0) begin
        check("load_unexpected", load, 0);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("load_hour", load_hour, e / 64);
        check("load_min", load_min, e % 64);
        check("load_sec", load_sec, 0);
        check("load_set_active", set_active, 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_h = 0; m_m = 0; m_phase = 0; m_tcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_event(input int kind);
    if (m_st == 0) begin
      if (kind == 0) begin
        m_h = cur_hour; m_m = cur_min; m_st = 1; m_phase = 0; m_tcnt = 0;
      end
    end else begin
      m_tcnt = 0;
      if (kind == 0) begin
        if (m_st == 1) m_st = 2;
        else begin
          exp_q.push_back(m_h * 64 + m_m);
          exp_total++;
          m_st = 0;
        end
      end else if (m_st == 1) begin
        m_h = (m_h + ((kind == 1) ? 1 : 23)) % 24;
      end else begin
        m_m = (m_m + ((kind == 1) ? 1 : 59)) % 60;
      end
    end
  endtask

  // A raw hold of d cycles keeps the debounced level high for d cycles.
  function automatic int n_events(input int kind, input int d);
    if (kind == 0) return 1;
    if (d < HOLD) return 1;
    return 2 + (d - HOLD) / REP;
  endfunction

  task automatic press(input int kind, input int hold);
    int n;
    n = n_events(kind, hold);
    repeat (n) model_event(kind);
    case (kind)
      0: btn_mode = 1'b1;
      1: btn_inc  = 1'b1;
      default: btn_dec = 1'b1;
    endcase
    tick(hold);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    tick(12);
  endtask

  task automatic sec_tick();
    if (m_st != 0) begin
      m_phase ^= 1;
      m_tcnt++;
      if (m_tcnt == TOUT) begin
        m_st = 0;
        m_tcnt = 0;
      end
    end
    sec_clk = 1'b1;
    tick(1);
    sec_clk = 1'b0;
    tick(2);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_active"}, set_active, (m_st != 0) ? 1 : 0);
    check({tag, "_dhour"}, disp_hour, m_h);
    check({tag, "_dmin"}, disp_min, m_m);
    check({tag, "_bhour"}, blink_hour, (m_st == 1 && m_phase == 1) ? 1 : 0);
    check({tag, "_bmin"}, blink_min, (m_st == 2 && m_phase == 1) ? 1 : 0);
  endtask

  initial begin
    reset = 1'b1; sec_clk = 1'b0;
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cur_hour = 5'd0; cur_min = 6'd0;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);
    check_state("reset");
    check("reset_load", load, 0);
    check("reset_lhour", load_hour, 0);
    check("reset_lmin", load_min, 0);

    // Latency: event 6 cycles after raw edge, state visible one edge later.
    cur_hour = 5'd9; cur_min = 6'd30;
    model_event(0);
    btn_mode = 1'b1;
    tick(6);
    check("lat_before", set_active, 0);
    tick(1);
    check("lat_after", set_active, 1);
    check("lat_hour", disp_hour, 9);
    check("lat_min", disp_min, 30);
    tick(1);
    btn_mode = 1'b0;
    tick(12);
    check_state("snap");

    press(1, 8); press(1, 8); press(0, 8); press(2, 8); press(0, 8);
    check_state("full");
    check("full_loads", loads_seen, 1);
    check("full_lhour", load_hour, 11);
    check("full_lmin", load_min, 29);

    cur_hour = 5'd23; cur_min = 6'd0;
    press(0, 8); press(1, 8);
    check("wrap_hour", disp_hour, 0);
    press(0, 8); press(2, 8);
    check("wrap_min", disp_min, 59);
    check("wrap_hour_kept", disp_hour, 0);
    press(0, 8);
    check_state("wrap");

    cur_hour = 5'd5; cur_min = 6'd58;
    press(0, 8); press(0, 8); press(1, 39);
    check("rep_min", disp_min, 3);
    check_state("rep");

    if (m_st != 0) m_tcnt = 0;
    btn_inc = 1'b1; btn_dec = 1'b1;
    tick(8);
    btn_inc = 1'b0; btn_dec = 1'b0;
    tick(12);
    check_state("incdec");
    press(0, 8);

    press(0, 8);
    sec_tick(); sec_tick();
    check_state("tout_pre");
    sec_tick();
    check("tout_active", set_active, 0);
    check_state("tout");

    btn_mode = 1'b1;
    tick(2);
    btn_mode = 1'b0;
    tick(12);
    check("glitch_active", set_active, 0);

    press(0, 8); press(0, 8);
    check_state("preset");
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    check_state("midreset");
    check("midreset_load", load, 0);
    check("midreset_lhour", load_hour, 0);
    check("midreset_lmin", load_min, 0);

    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 1)      press(0, $urandom_range(8, 30));
      else if (r <= 4) press(1, $urandom_range(8, 50));
      else if (r <= 7) press(2, $urandom_range(8, 50));
      else if (r == 8) sec_tick();
      else begin
        cur_hour = 5'($urandom_range(0, 23));
        cur_min  = 6'($urandom_range(0, 59));
        tick(1);
      end
      check_state("rand");
    end

    tick(5);
    check("load_count", loads_seen, exp_total);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
